// File: rtl/delay_initiator.sv
// delay_initiator: sequences a run of requests to an external delay timer.
//
// On an accepted start it raises delay, waits for the timer's done level,
// emits a step pulse, then holds delay low until done falls. Each request
// therefore sees at least one low cycle so the timer re-arms. This repeats
// until repeat_count delays have completed, and then finished pulses.
//
// Optional feature: define DELAY_TIMEOUT_EN to add a watchdog. It aborts a
// WAIT that lasts TIMEOUT_CYCLES clocks, pulses timeout_err and returns to
// IDLE. Without the macro no watchdog logic exists and timeout_err is 0.
//
// Ports:
//   CLK_100MHz   in   single clock, rising edge
//   Reset_n      in   asynchronous active-low reset
//   start        in   sequence request, sampled only in IDLE
//   repeat_count in   number of delays, latched when start is accepted
//   delay        out  registered request to the delay timer (high in WAIT)
//   done         in   completion level from the delay timer
//   busy         out  high in every state except IDLE
//   step         out  one-clock pulse per completed delay
//   finished     out  one-clock pulse on normal sequence end
//   timeout_err  out  one-clock pulse on watchdog abort
module delay_initiator #(
  parameter int unsigned CNT_W          = 8,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic             CLK_100MHz,
  input  logic             Reset_n,
  input  logic             start,
  input  logic [CNT_W-1:0] repeat_count,
  output logic             delay,
  input  logic             done,
  output logic             busy,
  output logic             step,
  output logic             finished,
  output logic             timeout_err
);

  typedef enum logic [1:0] {StIdle, StWait, StGap} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] remaining_q, remaining_d;
  logic             delay_q, delay_d;
  logic             step_q, step_d;
  logic             finished_q, finished_d;

`ifdef DELAY_TIMEOUT_EN
  localparam int unsigned WdW = $clog2(TIMEOUT_CYCLES + 1);
  // Value held on the last WAIT cycle before the watchdog fires.
  localparam logic [WdW-1:0] WdLast = WdW'(TIMEOUT_CYCLES - 1);

  logic [WdW-1:0] wdog_q, wdog_d;
  logic           tmo_q, tmo_d;
`endif

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    step_d      = 1'b0;
    finished_d  = 1'b0;
`ifdef DELAY_TIMEOUT_EN
    wdog_d      = wdog_q;
    tmo_d       = 1'b0;
`endif

    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (repeat_count != '0) begin
            remaining_d = repeat_count;
            state_d     = StWait;
`ifdef DELAY_TIMEOUT_EN
            wdog_d      = '0;
`endif
          end else begin
            finished_d = 1'b1;
          end
        end
      end

      StWait: begin
        // done has priority over a watchdog expiry on the same edge.
        if (done) begin
          state_d = StGap;
          step_d  = 1'b1;
          if (remaining_q != '0) begin
            remaining_d = remaining_q - CNT_W'(1);
          end
`ifdef DELAY_TIMEOUT_EN
        end else if (wdog_q == WdLast) begin
          state_d     = StIdle;
          remaining_d = '0;
          tmo_d       = 1'b1;
        end else begin
          wdog_d = wdog_q + WdW'(1);
`endif
        end
      end

      StGap: begin
        // Stay here until the timer drops done, so delay sees a low cycle.
        if (!done) begin
          if (remaining_q != '0) begin
            state_d = StWait;
`ifdef DELAY_TIMEOUT_EN
            wdog_d  = '0;
`endif
          end else begin
            state_d    = StIdle;
            finished_d = 1'b1;
          end
        end
      end

      default: begin
        state_d     = StIdle;
        remaining_d = '0;
      end
    endcase

    // delay is registered, so it tracks the next state exactly.
    delay_d = (state_d == StWait);
  end

  always_ff @(posedge CLK_100MHz or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q     <= StIdle;
      remaining_q <= '0;
      delay_q     <= 1'b0;
      step_q      <= 1'b0;
      finished_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      delay_q     <= delay_d;
      step_q      <= step_d;
      finished_q  <= finished_d;
    end
  end

`ifdef DELAY_TIMEOUT_EN
  always_ff @(posedge CLK_100MHz or negedge Reset_n) begin
    if (!Reset_n) begin
      wdog_q <= '0;
      tmo_q  <= 1'b0;
    end else begin
      wdog_q <= wdog_d;
      tmo_q  <= tmo_d;
    end
  end

  assign timeout_err = tmo_q;
`else
  assign timeout_err = 1'b0;
`endif

  assign delay    = delay_q;
  assign busy     = (state_q != StIdle);
  assign step     = step_q;
  assign finished = finished_q;

endmodule

// File: tb/tb_delay_initiator.sv
// Directed bench for delay_initiator. A simple timer model answers delay
// with done after a set latency and can hold done high after completion.
module tb_delay_initiator;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] repeat_count = 8'd0;
  logic       done = 1'b0;
  logic       delay, busy, step, finished, timeout_err;

  int n_cmp = 0;
  int n_err = 0;

  // Results of the most recent run_seq call.
  int r_steps, r_fins, r_wins, r_min_gap, r_fin_cyc, r_last_step;
  int r_excl, r_rearm, r_busy_seen, r_first_win, r_tmo, r_tmo_cyc;

  delay_initiator #(
    .CNT_W         (8),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .CLK_100MHz  (clk),
    .Reset_n     (rst_n),
    .start       (start),
    .repeat_count(repeat_count),
    .delay       (delay),
    .done        (done),
    .busy        (busy),
    .step        (step),
    .finished    (finished),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  // Called at a negedge: issues start now, then runs ncyc cycles sampling at
  // each negedge and driving the timer model. Cycle c is the negedge after
  // the c-th rising edge following start.
  task automatic run_seq(input logic [7:0] rc_v, input int lat, input int hold,
                         input int ncyc, input int restart_at, input logic [7:0] rc2);
    int   dcnt = 0;
    int   hold_cnt = 0;
    int   gap = 0;
    logic prev_delay = 1'b0;
    logic done_before;
    r_steps = 0; r_fins = 0; r_wins = 0; r_min_gap = 1000000; r_fin_cyc = -1;
    r_last_step = -1; r_excl = 0; r_rearm = 0; r_busy_seen = 0; r_first_win = -1;
    r_tmo = 0; r_tmo_cyc = -1;
    done = 1'b0;
    start = 1'b1;
    repeat_count = rc_v;
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (c == restart_at) begin
        start = 1'b1;
        repeat_count = rc2;
      end
      done_before = done;
      if (delay) begin
        if (!prev_delay) begin
          r_wins++;
          if (r_first_win < 0) r_first_win = c;
          if (r_wins > 1 && gap < r_min_gap) r_min_gap = gap;
          if (done_before) r_rearm++;
        end
        gap = 0;
      end else begin
        gap++;
      end
      if (busy) r_busy_seen = 1;
      if (step) begin r_steps++; r_last_step = c; end
      if (finished) begin r_fins++; r_fin_cyc = c; end
      if (timeout_err) begin r_tmo++; r_tmo_cyc = c; end
      if (int'(step) + int'(finished) + int'(timeout_err) > 1) r_excl++;
      // Timer model.
      if (delay) begin
        dcnt++;
        if (dcnt >= lat) begin
          if (!done) hold_cnt = hold;
          done = 1'b1;
        end
      end else begin
        dcnt = 0;
        if (done) begin
          if (hold_cnt > 0) hold_cnt--;
          else done = 1'b0;
        end
      end
      prev_delay = delay;
    end
    done = 1'b0;
    start = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    n_cmp++;
    if ({delay, busy, step, finished, timeout_err} !== 5'b0) begin
      n_err++;
      $display("FAIL reset_outputs: got %b expected 00000",
               {delay, busy, step, finished, timeout_err});
    end
    // start during reset must have no effect.
    start = 1'b1;
    repeat_count = 8'd4;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({delay, busy, finished} !== 3'b0) begin
      n_err++;
      $display("FAIL reset_hold: got %b expected 000", {delay, busy, finished});
    end
    start = 1'b0;
    // Release and start in the same cycle: first edge must accept it.
    rst_n = 1'b1;
    run_seq(8'd1, 2, 0, 6, 0, 8'd0);
    n_cmp++;
    if (r_first_win !== 1) begin
      n_err++;
      $display("FAIL reset_first_start: got cycle %0d expected 1", r_first_win);
    end
    n_cmp++;
    if (r_fin_cyc !== 4 || r_fins !== 1) begin
      n_err++;
      $display("FAIL reset_first_finish: got cycle %0d count %0d expected cycle 4 count 1",
               r_fin_cyc, r_fins);
    end
  endtask

  task automatic test_basic();
    run_seq(8'd3, 5, 0, 24, 0, 8'd0);
    n_cmp++;
    if (r_steps !== 3) begin
      n_err++; $display("FAIL basic_steps: got %0d expected 3", r_steps);
    end
    n_cmp++;
    if (r_wins !== 3) begin
      n_err++; $display("FAIL basic_windows: got %0d expected 3", r_wins);
    end
    n_cmp++;
    if (r_min_gap !== 1) begin
      n_err++; $display("FAIL basic_gap: got %0d expected 1", r_min_gap);
    end
    n_cmp++;
    if (r_fins !== 1 || r_fin_cyc !== 19 || r_last_step !== 18) begin
      n_err++;
      $display("FAIL basic_finish: got count %0d cycle %0d last_step %0d expected 1 19 18",
               r_fins, r_fin_cyc, r_last_step);
    end
    n_cmp++;
    if (r_excl !== 0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL basic_excl_busy: got overlap %0d busy %b expected 0 0", r_excl, busy);
    end
  endtask

  task automatic test_zero();
    run_seq(8'd0, 5, 0, 5, 0, 8'd0);
    n_cmp++;
    if (r_fins !== 1 || r_fin_cyc !== 1) begin
      n_err++;
      $display("FAIL zero_finish: got count %0d cycle %0d expected 1 1", r_fins, r_fin_cyc);
    end
    n_cmp++;
    if (r_wins !== 0 || r_busy_seen !== 0) begin
      n_err++;
      $display("FAIL zero_quiet: got windows %0d busy_seen %0d expected 0 0",
               r_wins, r_busy_seen);
    end
  endtask

  task automatic test_ignore_start();
    run_seq(8'd2, 5, 0, 20, 2, 8'd7);
    n_cmp++;
    if (r_steps !== 2) begin
      n_err++; $display("FAIL ignore_steps: got %0d expected 2", r_steps);
    end
    n_cmp++;
    if (r_fins !== 1 || r_fin_cyc !== 13) begin
      n_err++;
      $display("FAIL ignore_finish: got count %0d cycle %0d expected 1 13", r_fins, r_fin_cyc);
    end
  endtask

  task automatic test_done_hold();
    run_seq(8'd2, 3, 4, 22, 0, 8'd0);
    n_cmp++;
    if (r_steps !== 2) begin
      n_err++; $display("FAIL hold_steps: got %0d expected 2", r_steps);
    end
    n_cmp++;
    if (r_rearm !== 0) begin
      n_err++; $display("FAIL hold_rearm: got %0d early requests expected 0", r_rearm);
    end
    n_cmp++;
    if (r_min_gap !== 5) begin
      n_err++; $display("FAIL hold_gap: got %0d expected 5", r_min_gap);
    end
    n_cmp++;
    if (r_fin_cyc !== 17) begin
      n_err++; $display("FAIL hold_finish: got cycle %0d expected 17", r_fin_cyc);
    end
  endtask

  task automatic test_max_count();
    run_seq(8'd255, 1, 0, 520, 0, 8'd0);
    n_cmp++;
    if (r_steps !== 255) begin
      n_err++; $display("FAIL max_steps: got %0d expected 255", r_steps);
    end
    n_cmp++;
    if (r_fins !== 1 || r_fin_cyc !== 511) begin
      n_err++;
      $display("FAIL max_finish: got count %0d cycle %0d expected 1 511", r_fins, r_fin_cyc);
    end
    n_cmp++;
    if (busy !== 1'b0 || delay !== 1'b0) begin
      n_err++; $display("FAIL max_idle: got busy %b delay %b expected 0 0", busy, delay);
    end
  endtask

  task automatic test_reset_mid();
    int fins = 0;
    run_seq(8'd5, 100000, 0, 3, 0, 8'd0);
    n_cmp++;
    if (delay !== 1'b1) begin
      n_err++; $display("FAIL mid_in_wait: got delay %b expected 1", delay);
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (delay !== 1'b0 || busy !== 1'b0) begin
      n_err++; $display("FAIL mid_async: got delay %b busy %b expected 0 0", delay, busy);
    end
    repeat (3) begin
      @(negedge clk);
      if (finished) fins++;
    end
    n_cmp++;
    if (fins !== 0) begin
      n_err++; $display("FAIL mid_no_finish: got %0d expected 0", fins);
    end
    rst_n = 1'b1;
    run_seq(8'd1, 2, 0, 6, 0, 8'd0);
    n_cmp++;
    if (r_steps !== 1 || r_fins !== 1 || r_fin_cyc !== 4) begin
      n_err++;
      $display("FAIL mid_restart: got steps %0d fins %0d cycle %0d expected 1 1 4",
               r_steps, r_fins, r_fin_cyc);
    end
  endtask

  task automatic test_no_done();
`ifdef DELAY_TIMEOUT_EN
    run_seq(8'd1, 100000, 0, 20, 0, 8'd0);
    n_cmp++;
    if (r_tmo !== 1 || r_tmo_cyc !== 17) begin
      n_err++;
      $display("FAIL timeout_pulse: got count %0d cycle %0d expected 1 17", r_tmo, r_tmo_cyc);
    end
    n_cmp++;
    if (busy !== 1'b0 || delay !== 1'b0 || r_fins !== 0) begin
      n_err++;
      $display("FAIL timeout_idle: got busy %b delay %b fins %0d expected 0 0 0",
               busy, delay, r_fins);
    end
`else
    run_seq(8'd1, 100000, 0, 200, 0, 8'd0);
    n_cmp++;
    if (r_tmo !== 0 || r_steps !== 0) begin
      n_err++;
      $display("FAIL nowd_quiet: got timeouts %0d steps %0d expected 0 0", r_tmo, r_steps);
    end
    n_cmp++;
    if (delay !== 1'b1 || busy !== 1'b1) begin
      n_err++; $display("FAIL nowd_wait: got delay %b busy %b expected 1 1", delay, busy);
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
`endif
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero();
    test_ignore_start();
    test_done_hold();
    test_max_count();
    test_reset_mid();
    test_no_done();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
